// File: rtl/ipsxe_floating_point_norm_round_double_v1_0.sv
// Normalise-and-round stage after the FMA adder: leading-one detect, normalise,
// round-to-nearest-even, then flush-to-zero / saturate-to-infinity. 3-stage pipeline.
module ipsxe_floating_point_norm_round_double_v1_0 #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int W_USER    = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_aclken,
    input  logic                                 i_valid,
    input  logic [2*(MAN_WIDTH+1)+EXP_WIDTH+2:0] i_add_out,
    input  logic [W_USER-1:0]                    i_user,
    output logic                                 o_valid,
    output logic [EXP_WIDTH+MAN_WIDTH:0]         o_result,
    output logic [W_USER-1:0]                    o_user,
    output logic                                 o_overflow,
    output logic                                 o_underflow,
    output logic                                 o_inexact
);
    localparam int SW   = 2*(MAN_WIDTH+1)+1;
    localparam int RW   = 1+EXP_WIDTH+MAN_WIDTH;
    localparam int PW   = $clog2(SW);
    localparam int EPW  = EXP_WIDTH+3;
    localparam int BIAS = (2**(EXP_WIDTH-1))-1;
    localparam logic signed [EPW-1:0] E_MAX  = EPW'((2**EXP_WIDTH)-1);
    localparam logic signed [EPW-1:0] E_ZERO = '0;

    // ---------------- stage 1: leading-one detect ----------------
    logic [PW-1:0] p_d;
    logic          zero_d;

    always_comb begin
        p_d = '0;
        for (int i = 0; i < SW; i++) begin
            if (i_add_out[i]) p_d = PW'(i);
        end
    end
    assign zero_d = (i_add_out[SW-1:0] == '0);

    logic                 s1_valid_q;
    logic [W_USER-1:0]    s1_user_q;
    logic                 s1_sign_q;
    logic [EXP_WIDTH:0]   s1_exp_q;
    logic [SW-1:0]        s1_abs_q;
    logic [PW-1:0]        s1_p_q;
    logic                 s1_zero_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_abs_q   <= '0;
            s1_p_q     <= '0;
            s1_zero_q  <= 1'b0;
        end else if (i_aclken) begin
            s1_valid_q <= i_valid;
            s1_user_q  <= i_user;
            s1_sign_q  <= i_add_out[SW+EXP_WIDTH+1];
            s1_exp_q   <= i_add_out[SW +: EXP_WIDTH+1];
            s1_abs_q   <= i_add_out[SW-1:0];
            s1_p_q     <= p_d;
            s1_zero_q  <= zero_d;
        end
    end

    // ---------------- stage 2: normalise, extract G/S, exponent ----------------
    logic [PW-1:0]         shamt;
    logic [SW-1:0]         norm;
    logic signed [EPW-1:0] e_pre_d;
    logic                  zero2_d;

    assign shamt   = PW'(SW-1) - s1_p_q;
    assign norm    = s1_abs_q << shamt;
    // Wide enough for E up to 2^(EXP_WIDTH+1)-1 plus p, and for deep negatives.
    assign e_pre_d = EPW'(s1_exp_q) + EPW'(s1_p_q) - EPW'(BIAS) - EPW'(2*MAN_WIDTH);
    // After normalisation the top bit is clear only for a zero sum.
    assign zero2_d = s1_zero_q | ~norm[SW-1];

    logic                  s2_valid_q;
    logic [W_USER-1:0]     s2_user_q;
    logic                  s2_sign_q;
    logic                  s2_zero_q;
    logic [MAN_WIDTH-1:0]  s2_frac_q;
    logic                  s2_g_q;
    logic                  s2_s_q;
    logic signed [EPW-1:0] s2_e_pre_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_user_q  <= '0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_frac_q  <= '0;
            s2_g_q     <= 1'b0;
            s2_s_q     <= 1'b0;
            s2_e_pre_q <= '0;
        end else if (i_aclken) begin
            s2_valid_q <= s1_valid_q;
            s2_user_q  <= s1_user_q;
            s2_sign_q  <= s1_sign_q;
            s2_zero_q  <= zero2_d;
            s2_frac_q  <= norm[SW-2 -: MAN_WIDTH];
            s2_g_q     <= norm[SW-2-MAN_WIDTH];
            s2_s_q     <= |norm[SW-3-MAN_WIDTH:0];
            s2_e_pre_q <= e_pre_d;
        end
    end

    // ---------------- stage 3: round and classify ----------------
    logic                  round_up;
    logic [MAN_WIDTH:0]    frac_sum;
    logic signed [EPW-1:0] e_post;
    logic [RW-1:0]         result_d;
    logic                  ovf_d;
    logic                  unf_d;
    logic                  inx_d;

    assign round_up = s2_g_q & (s2_s_q | s2_frac_q[0]);
    assign frac_sum = {1'b0, s2_frac_q} + (MAN_WIDTH+1)'(round_up);
    assign e_post   = s2_e_pre_q + EPW'(frac_sum[MAN_WIDTH]);

    always_comb begin
        result_d = {s2_sign_q, e_post[EXP_WIDTH-1:0], frac_sum[MAN_WIDTH-1:0]};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inx_d    = s2_g_q | s2_s_q;
        if (s2_zero_q) begin
            result_d = '0;
            inx_d    = 1'b0;
        end else if (e_post >= E_MAX) begin
            result_d = {s2_sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            ovf_d    = 1'b1;
            inx_d    = 1'b1;
        end else if (e_post <= E_ZERO) begin
            result_d = {s2_sign_q, {(RW-1){1'b0}}};
            unf_d    = 1'b1;
            inx_d    = 1'b1;
        end
    end

    logic              out_valid_q;
    logic [RW-1:0]     out_result_q;
    logic [W_USER-1:0] out_user_q;
    logic              out_ovf_q;
    logic              out_unf_q;
    logic              out_inx_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_user_q   <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            out_inx_q    <= 1'b0;
        end else if (i_aclken) begin
            out_valid_q  <= s2_valid_q;
            out_result_q <= result_d;
            out_user_q   <= s2_user_q;
            out_ovf_q    <= ovf_d;
            out_unf_q    <= unf_d;
            out_inx_q    <= inx_d;
        end
    end

    assign o_valid     = out_valid_q;
    assign o_result    = out_result_q;
    assign o_user      = out_user_q;
    assign o_overflow  = out_ovf_q;
    assign o_underflow = out_unf_q;
    assign o_inexact   = out_inx_q;
endmodule

// File: tb/tb_ipsxe_floating_point_norm_round_double_v1_0.sv
// Self-checking bench for the normalise-and-round stage (EXP_WIDTH=8, MAN_WIDTH=23).
module tb_ipsxe_floating_point_norm_round_double_v1_0;
    localparam int SW = 49;
    localparam int IW = SW + 8 + 2;
    localparam int NITEMS = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        aclken;
    logic        valid;
    logic [IW-1:0] add_out;
    logic [0:0]  user;
    logic        o_valid;
    logic [31:0] o_result;
    logic [0:0]  o_user;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;

    int passed = 0;
    int total  = 0;

    logic        it_s [NITEMS];
    logic [8:0]  it_e [NITEMS];
    logic [48:0] it_a [NITEMS];
    logic [0:0]  it_u [NITEMS];

    ipsxe_floating_point_norm_round_double_v1_0 #(
        .EXP_WIDTH(8), .MAN_WIDTH(23), .W_USER(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_aclken(aclken), .i_valid(valid),
        .i_add_out(add_out), .i_user(user), .o_valid(o_valid), .o_result(o_result),
        .o_user(o_user), .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_inexact(o_inexact)
    );

    always #5 clk = ~clk;

    // Reference: value = a * 2^(E-127-127-46); round the integer a to 24 significant bits.
    // Returns {overflow, underflow, inexact, result[31:0]}.
    function automatic logic [34:0] ref_model(input logic s, input logic [8:0] e_in, input logic [48:0] a);
        logic [63:0] m, kept, rem, half;
        int p, ex, sh;
        logic inx;
        m = {15'b0, a};
        if (m == 64'd0) return '0;
        p = 0;
        for (int i = 0; i < SW; i++) if (m[i]) p = i;
        ex  = int'(e_in) - 127 + p - 46;
        inx = 1'b0;
        if (p > 23) begin
            sh   = p - 23;
            kept = m >> sh;
            rem  = m - (kept << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 64'd0);
            if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
        end else begin
            kept = m << (23 - p);
        end
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            ex++;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'd0};
        if (ex <= 0)   return {3'b011, s, 31'd0};
        return {2'b00, inx, s, 8'(ex), kept[22:0]};
    endfunction

    function automatic logic [36:0] observed();
        return {o_valid, o_user, o_overflow, o_underflow, o_inexact, o_result};
    endfunction

    task automatic drive(input logic s, input logic [8:0] e, input logic [48:0] a,
                         input logic [0:0] u, input logic v);
        add_out = {s, e, a};
        user    = u;
        valid   = v;
    endtask

    task automatic rand_item(output logic s, output logic [8:0] e, output logic [48:0] a,
                             output logic [0:0] u);
        logic [63:0] r;
        int bits;
        s    = 1'($urandom_range(0, 1));
        e    = 9'($urandom_range(90, 430));
        u    = 1'($urandom_range(0, 1));
        bits = $urandom_range(0, 49);
        r    = {$urandom, $urandom};
        if (bits == 0) r = 64'd0;
        else r = (r & ((64'd1 << bits) - 64'd1)) | (64'd1 << (bits - 1));
        a = r[48:0];
    endtask

    // Drives one valid item (caller is #1 after an edge) and returns outputs after 3 edges.
    task automatic run_one(input logic s, input logic [8:0] e, input logic [48:0] a,
                           output logic [36:0] obs);
        drive(s, e, a, 1'b1, 1'b1);
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        obs = observed();
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (observed() !== 37'd0) $display("FAIL reset_async outputs=%h required=0", observed());
        else passed++;
        @(posedge clk); #1;
        total++;
        if (observed() !== 37'd0) $display("FAIL reset_clocked outputs=%h required=0", observed());
        else passed++;
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input logic s[], input logic [8:0] e[],
                             input logic [48:0] a[], input logic [34:0] exp_v[]);
        logic [36:0] obs;
        for (int i = 0; i < a.size(); i++) begin
            run_one(s[i], e[i], a[i], obs);
            total++;
            if (obs !== {1'b1, 1'b1, exp_v[i]})
                $display("FAIL %s[%0d] got v/u/flags/res=%h required=%h", tag, i, obs, {2'b11, exp_v[i]});
            else passed++;
            $display("%s[%0d] result=%h flags(o,u,x)=%b", tag, i, obs[31:0], obs[34:32]);
        end
    endtask

    task automatic test_normal_round;
        logic        s[] = '{0, 0, 0, 0, 0};
        logic [8:0]  e[] = '{254, 254, 254, 254, 254};
        logic [48:0] a[] = '{49'd1 << 46, 49'd1 << 47, (49'd1 << 46) | (49'd1 << 22),
                             (49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22),
                             ((49'd1 << 47) - 49'd1) & ~((49'd1 << 22) - 49'd1)};
        logic [34:0] x[] = '{{3'b000, 32'h3F800000}, {3'b000, 32'h40000000},
                             {3'b001, 32'h3F800000}, {3'b001, 32'h3F800002},
                             {3'b001, 32'h40000000}};
        user = 1'b1;
        run_table("normal_round", s, e, a, x);
    endtask

    task automatic test_overflow_underflow;
        logic        s[] = '{0, 1, 1};
        logic [8:0]  e[] = '{510, 100, 254};
        logic [48:0] a[] = '{49'd1 << 47, 49'd1 << 46, 49'd0};
        logic [34:0] x[] = '{{3'b101, 32'h7F800000}, {3'b011, 32'h80000000},
                             {3'b000, 32'h00000000}};
        run_table("ovf_unf_zero", s, e, a, x);
    endtask

    task automatic test_stream(input bit stall, input string tag);
        int n = 0;
        int iter = 0;
        int idx;
        logic [36:0] snap, exp_o;
        logic ds; logic [8:0] de; logic [48:0] da; logic [0:0] du;
        snap = observed();
        while (n < NITEMS + 2 && iter < 400) begin
            iter++;
            aclken = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (aclken && n < NITEMS) begin
                drive(it_s[n], it_e[n], it_a[n], it_u[n], 1'b1);
            end else begin
                rand_item(ds, de, da, du);
                drive(ds, de, da, du, aclken ? 1'b0 : 1'($urandom_range(0, 1)));
            end
            @(posedge clk); #1;
            if (aclken) begin
                n++;
                if (n >= 3) begin
                    idx   = n - 3;
                    exp_o = {1'b1, it_u[idx], ref_model(it_s[idx], it_e[idx], it_a[idx])};
                    total++;
                    if (observed() !== exp_o)
                        $display("FAIL %s item %0d got=%h required=%h", tag, idx, observed(), exp_o);
                    else passed++;
                    $display("%s item %0d result=%h user=%0d", tag, idx, o_result, o_user);
                end
            end else begin
                total++;
                if (observed() !== snap)
                    $display("FAIL %s hold got=%h required=%h", tag, observed(), snap);
                else passed++;
            end
            snap = observed();
        end
        if (n < NITEMS + 2) begin
            total++;
            $display("FAIL %s timeout enabled_edges=%0d required=%0d", tag, n, NITEMS + 2);
        end
        aclken = 1'b1;
        valid  = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < NITEMS; i++) rand_item(it_s[i], it_e[i], it_a[i], it_u[i]);
        test_stream(1'b0, "back_to_back");
    endtask

    task automatic test_stall;
        test_stream(1'b1, "stall");
    endtask

    task automatic test_reset_midstream;
        logic        s[4]; logic [8:0] e[4]; logic [48:0] a[4]; logic [0:0] u[4];
        logic cs; logic [8:0] ce; logic [48:0] ca; logic [0:0] cu;
        logic [36:0] exp_o;
        for (int i = 0; i < 4; i++) begin
            rand_item(s[i], e[i], a[i], u[i]);
            drive(s[i], e[i], a[i], u[i], 1'b1);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        exp_o = {1'b1, u[1], ref_model(s[1], e[1], a[1])};
        total++;
        if (observed() !== exp_o) $display("FAIL pre_reset got=%h required=%h", observed(), exp_o);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (observed() !== 37'd0) $display("FAIL reset_midstream got=%h required=0", observed());
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (o_valid !== 1'b0) $display("FAIL stale_after_reset edge %0d o_valid=%b required=0", i, o_valid);
            else passed++;
        end
        rand_item(cs, ce, ca, cu);
        drive(cs, ce, ca, cu, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            if (i < 3) begin
                total++;
                if (o_valid !== 1'b0) $display("FAIL latency edge %0d o_valid=%b required=0", i, o_valid);
                else passed++;
            end
        end
        exp_o = {1'b1, cu, ref_model(cs, ce, ca)};
        total++;
        if (observed() !== exp_o) $display("FAIL post_reset_item got=%h required=%h", observed(), exp_o);
        else passed++;
        $display("post_reset item result=%h", o_result);
    endtask

    initial begin
        rst = 1'b1; aclken = 1'b1; valid = 1'b0; add_out = '0; user = '0;
        test_reset;
        test_normal_round;
        test_overflow_underflow;
        test_back_to_back;
        test_stall;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
